// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared constants, widths and state encoding for the RGBI scan doubler
package video_pkg;

  localparam int LINE_PIXELS  = 256;
  localparam int OUT_H_TOTAL  = 402;
  localparam int OUT_HS_START = 330;
  localparam int OUT_HS_WIDTH = 48;

  // Bit positions inside a 4-bit RGBI pixel
  localparam int RGBI_RED       = 3;
  localparam int RGBI_GREEN     = 2;
  localparam int RGBI_BLUE      = 1;
  localparam int RGBI_INTENSITY = 0;

  localparam int IDX_W  = $clog2(LINE_PIXELS);
  localparam int ADDR_W = IDX_W + 1;
  localparam int PTR_W  = $clog2(LINE_PIXELS + 1);
  localparam int HCNT_W = $clog2(OUT_H_TOTAL);

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [HCNT_W-1:0] hcnt_t;

  localparam ptr_t  PTR_FULL = ptr_t'(LINE_PIXELS);
  localparam hcnt_t H_LAST   = hcnt_t'(OUT_H_TOTAL - 1);
  localparam hcnt_t HS_BEGIN = hcnt_t'(OUT_HS_START);
  localparam hcnt_t HS_END   = hcnt_t'(OUT_HS_START + OUT_HS_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS0 = 2'd1,
    PASS1 = 2'd2
  } state_t;

endpackage

// File: rtl/line_buffer_ram.sv
// rtl/line_buffer_ram.sv - ping-pong line store, one write port and one registered read port
module line_buffer_ram
  import video_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        rd_data
);

  // Address is {buffer select, pixel index}; contents are never cleared.
  logic [3:0] mem [2*LINE_PIXELS];

  // Synchronous write plus registered read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rgbi_scan_doubler.sv
// rtl/rgbi_scan_doubler.sv - captures each RGBI line and replays it twice at double line rate
module rgbi_scan_doubler
  import video_pkg::*;
(
  input  logic       master_clock,
  input  logic       reset,
  input  logic       in_pix_en,
  input  logic       in_active,
  input  logic [3:0] in_rgbi,
  input  logic       in_hsync,
  input  logic       in_vsync,
  output logic [3:0] out_rgbi,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic       overflow,
  output logic       resync,
  output logic       rate_err
);

  state_t     state, state_next;
  hcnt_t      hcnt, hcnt_next;
  ptr_t       wr_ptr, rd_len;
  logic       wr_sel, rd_sel;
  logic       hsync_prev, pix_en_prev, vsync_lat;
  logic       line_end, pix_wr;
  logic       pass_active, pix_valid_d, hsync_d, vsync_load;
  logic       pix_valid;
  logic [3:0] ram_q;

  assign line_end = !in_hsync && hsync_prev;
  assign pix_wr   = in_pix_en && in_active && (wr_ptr < PTR_FULL);

  line_buffer_ram u_ram (
    .clk     (master_clock),
    .wr_en   (pix_wr),
    .wr_addr ({wr_sel, wr_ptr[IDX_W-1:0]}),
    .wr_data (in_rgbi),
    .rd_addr ({rd_sel, hcnt[IDX_W-1:0]}),
    .rd_data (ram_q)
  );

  // Replay state and horizontal counter registers
  always_ff @(posedge master_clock) begin
    if (reset) begin
      state <= IDLE;
      hcnt  <= '0;
    end else begin
      state <= state_next;
      hcnt  <= hcnt_next;
    end
  end

  // Next replay state: a line end always restarts the first pass
  always_comb begin
    state_next = state;
    hcnt_next  = hcnt;
    if (line_end) begin
      state_next = PASS0;
      hcnt_next  = '0;
    end else begin
      case (state)
        PASS0: begin
          if (hcnt == H_LAST) begin
            state_next = PASS1;
            hcnt_next  = '0;
          end else begin
            hcnt_next = hcnt + 1'b1;
          end
        end
        PASS1: begin
          if (hcnt == H_LAST) begin
            state_next = IDLE;
            hcnt_next  = '0;
          end else begin
            hcnt_next = hcnt + 1'b1;
          end
        end
        default: hcnt_next = '0;
      endcase
    end
  end

  // Output decode for the current hcnt; registered on the next edge
  always_comb begin
    pass_active = (state == PASS0) || (state == PASS1);
    pix_valid_d = pass_active && (hcnt < rd_len);
    hsync_d     = !(pass_active && (hcnt >= HS_BEGIN) && (hcnt < HS_END));
    vsync_load  = (state == PASS0) && (hcnt == '0);
  end

  // Output registers; the RAM's registered read lines up with pix_valid
  always_ff @(posedge master_clock) begin
    if (reset) begin
      pix_valid <= 1'b0;
      out_hsync <= 1'b1;
      out_vsync <= 1'b1;
    end else begin
      pix_valid <= pix_valid_d;
      out_hsync <= hsync_d;
      if (vsync_load) begin
        out_vsync <= vsync_lat;
      end
    end
  end

  assign out_rgbi = pix_valid ? ram_q : 4'h0;

  // Capture side: write pointer, buffer swap on line end, sticky error flags
  always_ff @(posedge master_clock) begin
    if (reset) begin
      wr_sel      <= 1'b0;
      wr_ptr      <= '0;
      rd_sel      <= 1'b0;
      rd_len      <= '0;
      hsync_prev  <= 1'b1;
      pix_en_prev <= 1'b0;
      vsync_lat   <= 1'b1;
      overflow    <= 1'b0;
      resync      <= 1'b0;
      rate_err    <= 1'b0;
    end else begin
      hsync_prev  <= in_hsync;
      pix_en_prev <= in_pix_en;
      if (in_pix_en && pix_en_prev) begin
        rate_err <= 1'b1;
      end
      if (in_pix_en && in_active && (wr_ptr == PTR_FULL)) begin
        overflow <= 1'b1;
      end
      if (line_end) begin
        // A coincident pixel lands in the old buffer and counts toward its length
        rd_len    <= wr_ptr + ptr_t'(pix_wr);
        rd_sel    <= wr_sel;
        wr_sel    <= ~wr_sel;
        wr_ptr    <= '0;
        vsync_lat <= in_vsync;
        if ((state == PASS0) || ((state == PASS1) && (hcnt != H_LAST))) begin
          resync <= 1'b1;
        end
      end else if (pix_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: doc/rgbi_scan_doubler.md
Name: rgbi_scan_doubler

Overview:
- Sits directly downstream of the video/glue generator. It consumes that block's RGBI pixel stream with hsync and vsync, and drives the monitor connector.
- Captures each incoming scanline into one half of a ping-pong line buffer. It replays the previous line twice at the master_clock rate, which doubles the line rate for 31 kHz monitors.
- Single clock domain; the video source is clocked by the same master_clock.

Parameters:
- LINE_PIXELS, 256, maximum active pixels stored per input line.
- OUT_H_TOTAL, 402, master_clock cycles per output line. Two output lines equal one input line.
- OUT_HS_START, 330, output hcnt at which out_hsync goes low.
- OUT_HS_WIDTH, 48, out_hsync low duration in clocks.

Ports:
- master_clock  in  1  system clock. All logic is clocked on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_pix_en  in  1  pixel strobe. Asserted at most once per 2 clocks.
- in_active  in  1  high when the source is inside both hblank and vblank active windows.
- in_rgbi  in  4  {red, green, blue, intensity}.
- in_hsync  in  1  active-low source hsync.
- in_vsync  in  1  active-low source vsync.
- out_rgbi  out  4  doubled pixel stream {red, green, blue, intensity}.
- out_hsync  out  1  active-low output hsync.
- out_vsync  out  1  active-low output vsync.
- overflow  out  1  sticky: an input line exceeded LINE_PIXELS.
- resync  out  1  sticky: a line-end arrived before the second replay pass finished.
- rate_err  out  1  sticky: in_pix_en was asserted on 2 consecutive clocks.

Behaviour:
- Interface: one clock, master_clock. Reset is synchronous and active-high, named reset.
- Reset values:
  - out_rgbi = 0, out_hsync = 1, out_vsync = 1, overflow = resync = rate_err = 0.
  - wr_sel = 0, wr_ptr = 0, hsync_prev = 1, state = IDLE.
- Reset asserted mid-line abandons all buffered data. Buffer RAM contents are not cleared.
- Line-end event: in_hsync == 0 while hsync_prev == 1. hsync_prev is sampled every clock.
- Write side:
  - Trigger: in_pix_en && in_active, with wr_ptr < LINE_PIXELS.
  - Action: write in_rgbi to buf[wr_sel][wr_ptr], then wr_ptr++.
  - A write with wr_ptr == LINE_PIXELS is dropped and sets overflow.
  - A pixel coincident with the line-end event is written to the old buffer before the swap.
- On the line-end event:
  - rd_len <= final pixel count, including any coincident pixel.
  - rd_sel <= wr_sel, then wr_sel <= ~wr_sel and wr_ptr <= 0.
  - vsync_lat <= in_vsync.
  - state <= PASS0, hcnt <= 0.
- States:
  - IDLE: outputs blank, out_hsync = 1.
  - PASS0 → PASS1 when hcnt == OUT_H_TOTAL-1 (hcnt <= 0).
  - PASS1 → IDLE when hcnt == OUT_H_TOTAL-1.
  - A line-end event in PASS0 or PASS1 restarts PASS0 immediately with the new buffer. If it arrives in PASS0, or in PASS1 before the final count, it also sets resync. A line-end in IDLE is normal.
- In PASS0/PASS1, per clock:
  - hcnt++ (width is clog2(OUT_H_TOTAL)).
  - Read address = hcnt. The RAM read is registered.
- Outputs are registered with 1-clock latency. The values driven in the cycle after hcnt == k are:
  - out_rgbi = (k < rd_len) ? buf[rd_sel][k] : 0.
  - out_hsync = 0 iff OUT_HS_START <= k < OUT_HS_START+OUT_HS_WIDTH.
  - out_vsync = vsync_lat. It changes only at the registered output of PASS0 hcnt 0.
- A line with rd_len == 0 (vertical blank) still produces 2 output lines, black, with hsync pulses.
- rate_err is set when in_pix_en is high on 2 consecutive clocks. The second pixel is still written.
- No read/write conflict: the write buffer is always ~rd_sel after a swap.

Decomposition:
- Package video_pkg holds:
  - constants for LINE_PIXELS, OUT_H_TOTAL, OUT_HS_START, OUT_HS_WIDTH;
  - RGBI bit positions (RED=3, GREEN=2, BLUE=1, INTENSITY=0);
  - state encoding IDLE / PASS0 / PASS1.
- Sub-module line_buffer_ram:
  - 2×LINE_PIXELS × 4-bit memory with 1 write port and 1 registered read port;
  - address = {sel, index}.

Test Plan:
- Reset, then idle inputs for 1000 clocks → out_rgbi = 0, out_hsync = 1, out_vsync = 1, all flags 0.
- Line of 128 pixels with in_rgbi = index[3:0], strobed every 2 clocks, then hsync falling → next 2×402 clocks show pixels 0..127 at hcnt+1 twice, black beyond. out_hsync is low for 48 clocks starting 1 clock after hcnt = 330 in each pass.
- Line of 300 pixels → only the first 256 replayed; overflow = 1 and stays 1 until reset.
- Line-end events 500 clocks apart → PASS1 aborted at hcnt 97; resync = 1; new line replay starts at hcnt 0.
- in_vsync low at 2 consecutive line-ends, with 0 active pixels → out_vsync low for exactly 4 output lines, aligned to PASS0 start; output black.
- Reset asserted at PASS0 hcnt 200 → next clock outputs return to reset values and state = IDLE. The following line-end replays only pixels written after reset.
